wb_timeout_bridge: RTL and testbench



---
 rtl/wb_bridge_pkg.sv | 14 +
 rtl/wb_timeout_timer.sv | 30 +++
 rtl/wb_timeout_bridge.sv | 155 +++++++++++++++
 tb/tb_wb_timeout_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the Wishbone timeout bridge.
// Holds the FSM state encoding, the default error word and the timeout-counter width.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int          TO_COUNT_W       = 8;

endpackage

// File: rtl/wb_timeout_timer.sv
// Per-transfer cycle counter: cleared while idle, counts while busy.
// expire is combinational and high on the last allowed busy cycle.
module wb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge that answers hung slaves with ERR_DATA/err after TIMEOUT_CYCLES.
// 3-cycle zero-wait round trip; upstream stalls until ack. Sticky irq only with WB_TIMEOUT_IRQ_EN.
module wb_timeout_bridge
    import wb_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m_wb_cyc_i,
    input  logic                    m_wb_stb_i,
    input  logic                    m_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m_wb_sel_i,
    output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
    output logic                    m_wb_ack_o,
    output logic                    m_wb_err_o,
    output logic                    s_wb_cyc_o,
    output logic                    s_wb_stb_o,
    output logic                    s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
    input  logic                    s_wb_ack_i,
    input  logic                    s_wb_err_i,
    output logic [TO_COUNT_W-1:0]   to_count_o
`ifdef WB_TIMEOUT_IRQ_EN
    ,
    output logic                    irq_o,
    input  logic                    irq_clr_i
`endif
);

    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

    state_t                    state, state_nxt;
    logic [ADDR_WIDTH-1:0]     adr_q;
    logic [DATA_WIDTH-1:0]     wdat_q, rdat_q;
    logic [DATA_WIDTH/8-1:0]   sel_q;
    logic                      we_q, err_q;
    logic                      expire, timeout_evt;
    logic [TO_COUNT_W-1:0]     to_cnt_q;

    wb_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == IDLE),
        .en     (state == BUSY),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Abort beats ack beats err beats timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (m_wb_cyc_i && m_wb_stb_i) state_nxt = BUSY;
            BUSY: begin
                if (!m_wb_cyc_i)                           state_nxt = IDLE;
                else if (s_wb_ack_i || s_wb_err_i || expire) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        m_wb_ack_o = 1'b0;
        m_wb_err_o = 1'b0;
        case (state)
            BUSY: begin
                s_wb_cyc_o = 1'b1;
                s_wb_stb_o = 1'b1;
            end
            RESP: begin
                m_wb_ack_o = 1'b1;
                m_wb_err_o = err_q;
            end
            default: ;
        endcase
    end

    assign timeout_evt = (state == BUSY) && m_wb_cyc_i && !s_wb_ack_i && !s_wb_err_i && expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            we_q   <= 1'b0;
        end else if (state == IDLE && m_wb_cyc_i && m_wb_stb_i) begin
            adr_q  <= m_wb_adr_i;
            wdat_q <= m_wb_dat_i;
            sel_q  <= m_wb_sel_i;
            we_q   <= m_wb_we_i;
        end
    end

    // Read data register doubles as the upstream return path and holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
            err_q  <= 1'b0;
        end else if (state == BUSY && m_wb_cyc_i) begin
            if (s_wb_ack_i) begin
                err_q <= 1'b0;
                if (!we_q) rdat_q <= s_wb_dat_i;
            end else if (s_wb_err_i || expire) begin
                err_q  <= 1'b1;
                rdat_q <= ERR_WORD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (timeout_evt && (to_cnt_q != '1)) begin
            to_cnt_q <= to_cnt_q + TO_COUNT_W'(1);
        end
    end

`ifdef WB_TIMEOUT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           irq_q <= 1'b0;
        else if (timeout_evt) irq_q <= 1'b1;
        else if (irq_clr_i)   irq_q <= 1'b0;
    end

    assign irq_o = irq_q;
`endif

    assign s_wb_we_o  = we_q;
    assign s_wb_adr_o = adr_q;
    assign s_wb_dat_o = wdat_q;
    assign s_wb_sel_o = sel_q;
    assign m_wb_dat_o = rdat_q;
    assign to_count_o = to_cnt_q;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Bench for wb_timeout_bridge with TIMEOUT_CYCLES=8; expected responses are queued at issue time.
module tb_wb_timeout_bridge;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
    logic [31:0] m_adr = '0, m_dat = '0;
    logic [3:0]  m_sel = '0;
    logic [31:0] m_dat_o;
    logic        m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_o;
    logic [3:0]  s_sel;
    logic [31:0] s_rdata = '0;
    logic        s_ack, s_err;
    logic [7:0]  to_count;

    // Slave model: 0 = ack, 1 = err, 2 = never respond; fires when stb_cnt == resp_at.
    int          mode = 0;
    int          resp_at = 0;
    int          stb_cnt;

    logic [31:0] cur_adr = '0, cur_dat = '0;
    logic [3:0]  cur_sel = '0;
    logic        cur_we = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          stb_len;
        bit          chk_dat;
    } exp_t;
    exp_t exp_q[$];

    assign s_ack = s_stb && (mode == 0) && (stb_cnt == resp_at);
    assign s_err = s_stb && (mode == 1) && (stb_cnt == resp_at);

`ifdef WB_TIMEOUT_IRQ_EN
    logic irq;
    logic clr_force = 1'b0;
    logic clr_on_last = 1'b0;
    logic irq_clr;
    assign irq_clr = clr_force | (clr_on_last & s_stb & (stb_cnt == TO - 1));
`endif

    wb_timeout_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ERR_DATA      (32'hDEAD_BEEF),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_wb_cyc_i (m_cyc),
        .m_wb_stb_i (m_stb),
        .m_wb_we_i  (m_we),
        .m_wb_adr_i (m_adr),
        .m_wb_dat_i (m_dat),
        .m_wb_sel_i (m_sel),
        .m_wb_dat_o (m_dat_o),
        .m_wb_ack_o (m_ack),
        .m_wb_err_o (m_err),
        .s_wb_cyc_o (s_cyc),
        .s_wb_stb_o (s_stb),
        .s_wb_we_o  (s_we),
        .s_wb_adr_o (s_adr),
        .s_wb_dat_o (s_dat_o),
        .s_wb_sel_o (s_sel),
        .s_wb_dat_i (s_rdata),
        .s_wb_ack_i (s_ack),
        .s_wb_err_i (s_err),
        .to_count_o (to_count)
`ifdef WB_TIMEOUT_IRQ_EN
        ,
        .irq_o      (irq),
        .irq_clr_i  (irq_clr)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     stb_cnt <= 0;
        else if (s_stb) stb_cnt <= stb_cnt + 1;
        else            stb_cnt <= 0;
    end

    // Monitor: request fields while strobing, and scoreboard pop on every ack.
    always @(negedge clk) begin
        if (rst_n && s_stb) begin
            checks++;
            if (s_adr !== cur_adr || s_dat_o !== cur_dat || s_sel !== cur_sel || s_we !== cur_we || s_cyc !== 1'b1) begin
                errors++;
                $display("FAIL req_fields: got adr=%h dat=%h sel=%b we=%b cyc=%b, want adr=%h dat=%h sel=%b we=%b cyc=1",
                         s_adr, s_dat_o, s_sel, s_we, s_cyc, cur_adr, cur_dat, cur_sel, cur_we);
            end
        end
        if (rst_n && m_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack with dat=%h err=%b, want no ack", m_dat_o, m_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (m_err !== e.err || (e.chk_dat && m_dat_o !== e.dat) || stb_cnt != e.stb_len) begin
                    errors++;
                    $display("FAIL response: got dat=%h err=%b stb_len=%0d, want dat=%h err=%b stb_len=%0d",
                             m_dat_o, m_err, stb_cnt, e.dat, e.err, e.stb_len);
                end
            end
        end
    end

    // Drives one request and waits (bounded) for its ack; keep leaves cyc/stb up for a follow-on.
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit keep, output int lat, output bit got);
        cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat; m_sel = sel;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (m_ack) got = 1'b1;
        end
        @(posedge clk); #1;
        if (!keep) begin
            m_cyc = 1'b0; m_stb = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_cyc, s_stb, s_we, m_ack, m_err} !== 5'b0 || s_adr !== '0 || s_dat_o !== '0 || s_sel !== '0) begin
            errors++;
            $display("FAIL reset_s_outputs: got cyc=%b stb=%b we=%b ack=%b err=%b adr=%h dat=%h sel=%b, want all 0",
                     s_cyc, s_stb, s_we, m_ack, m_err, s_adr, s_dat_o, s_sel);
        end
        checks++;
        if (m_dat_o !== 32'h0 || to_count !== 8'h0) begin
            errors++;
            $display("FAIL reset_m_dat_count: got dat=%h to_count=%0d, want 0 and 0", m_dat_o, to_count);
        end
`ifdef WB_TIMEOUT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, want 0", irq);
        end
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_read();
        int lat; bit got;
        mode = 0; resp_at = 0; s_rdata = 32'h1234_5678;
        exp_q.push_back('{32'h1234_5678, 1'b0, 1, 1'b1});
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1'b0, lat, got);
        checks++;
        if (!got || lat != 3) begin
            errors++;
            $display("FAIL zero_wait_latency: got ack=%b after %0d cycles, want ack after 3", got, lat);
        end
        checks++;
        if (to_count !== 8'd0) begin
            errors++;
            $display("FAIL zero_wait_to_count: got %0d, want 0", to_count);
        end
    endtask

    task automatic test_write_delayed();
        int lat; bit got;
        mode = 0; resp_at = 5; s_rdata = 32'hFFFF_0000;
        exp_q.push_back('{32'h0, 1'b0, 6, 1'b0});
        xfer(1'b1, 32'h3000_0104, 32'hA5A5_5A5A, 4'b0011, 1'b0, lat, got);
        checks++;
        if (!got || lat != 8) begin
            errors++;
            $display("FAIL write_delayed_latency: got ack=%b after %0d cycles, want ack after 8", got, lat);
        end
    endtask

    task automatic test_timeout();
        int lat; bit got;
        mode = 2;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b1, TO, 1'b1});
        xfer(1'b0, 32'h3FFF_0000, 32'h0, 4'hF, 1'b0, lat, got);
        checks++;
        if (!got || lat != TO + 2) begin
            errors++;
            $display("FAIL timeout_latency: got ack=%b after %0d cycles, want ack after %0d", got, lat, TO + 2);
        end
        checks++;
        if (to_count !== 8'd1) begin
            errors++;
            $display("FAIL timeout_to_count: got %0d, want 1", to_count);
        end
`ifdef WB_TIMEOUT_IRQ_EN
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL timeout_irq: got %b, want 1", irq);
        end
`endif
    endtask

    task automatic test_ack_last_cycle();
        int lat; bit got;
        mode = 0; resp_at = TO - 1; s_rdata = 32'hCAFE_0001;
        exp_q.push_back('{32'hCAFE_0001, 1'b0, TO, 1'b1});
        xfer(1'b0, 32'h3000_0200, 32'h0, 4'hF, 1'b0, lat, got);
        checks++;
        if (!got || to_count !== 8'd1) begin
            errors++;
            $display("FAIL ack_last_cycle: got ack=%b to_count=%0d, want ack=1 to_count=1", got, to_count);
        end
    endtask

    task automatic test_slave_err();
        int lat; bit got;
`ifdef WB_TIMEOUT_IRQ_EN
        clr_force = 1'b1;
        @(posedge clk); #1;
        clr_force = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear: got %b, want 0", irq);
        end
`endif
        mode = 1; resp_at = 2;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b1, 3, 1'b1});
        xfer(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1'b0, lat, got);
        checks++;
        if (!got || to_count !== 8'd1) begin
            errors++;
            $display("FAIL slave_err: got ack=%b to_count=%0d, want ack=1 to_count=1", got, to_count);
        end
`ifdef WB_TIMEOUT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL slave_err_irq: got %b, want 0", irq);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat; bit got;
        logic [31:0] d;
        mode = 0; resp_at = 0;
        for (int i = 0; i < 4; i++) begin
            d = 32'h5000_0000 + 32'(i * 17);
            s_rdata = d;
            exp_q.push_back('{d, 1'b0, 1, 1'b1});
            xfer(1'b0, 32'h3000_1000 + 32'(i * 4), 32'h0, 4'hF, (i != 3), lat, got);
            checks++;
            if (!got || lat != 3) begin
                errors++;
                $display("FAIL back_to_back_%0d: got ack=%b after %0d cycles, want ack after 3", i, got, lat);
            end
        end
    endtask

    task automatic test_saturate();
        int lat; bit got;
        mode = 2;
`ifdef WB_TIMEOUT_IRQ_EN
        clr_force = 1'b1;
        @(posedge clk); #1;
        clr_force = 1'b0;
`endif
        for (int i = 0; i < 256; i++) begin
`ifdef WB_TIMEOUT_IRQ_EN
            clr_on_last = (i == 255);
`endif
            exp_q.push_back('{32'hDEAD_BEEF, 1'b1, TO, 1'b1});
            xfer(1'b0, 32'h3FFF_0000 + 32'(i), 32'h0, 4'hF, 1'b0, lat, got);
            if (i == 252) begin
                checks++;
                if (to_count !== 8'd254) begin
                    errors++;
                    $display("FAIL to_count_pre_sat: got %0d, want 254", to_count);
                end
            end
        end
        checks++;
        if (to_count !== 8'd255) begin
            errors++;
            $display("FAIL to_count_saturate: got %0d, want 255", to_count);
        end
`ifdef WB_TIMEOUT_IRQ_EN
        clr_on_last = 1'b0;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set_wins: got %b, want 1", irq);
        end
`endif
    endtask

    task automatic test_reset_mid_busy();
        int waited = 0;
        int acks = 0;
        mode = 2;
        cur_we = 1'b0; cur_adr = 32'h3000_0400; cur_dat = 32'h0; cur_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = cur_adr; m_dat = 32'h0; m_sel = 4'hF;
        while (!s_stb && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_stb !== 1'b0 || s_cyc !== 1'b0 || m_ack !== 1'b0 || waited >= 20) begin
            errors++;
            $display("FAIL reset_mid_busy: got stb=%b cyc=%b ack=%b waited=%0d, want 0 0 0 and strobe seen",
                     s_stb, s_cyc, m_ack, waited);
        end
        checks++;
        if (to_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_clears_count: got %0d, want 0", to_count);
        end
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (m_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_no_ack: got %0d acks, want 0", acks);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_delayed();
        test_timeout();
        test_ack_last_cycle();
        test_slave_err();
        test_back_to_back();
        test_saturate();
        test_reset_mid_busy();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_acks: got %0d outstanding, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
